fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core. Holds the program counter, drives the instruction-memory address, and captures the returned word together with its PC into the IF/ID pipeline register. Sits directly upstream of the instruction memory, which is a combinational read, and feeds the decode stage. Honours stall and flush requests from the hazard unit and PC redirects from execute.

---
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage of the pipelined RV32I core. Holds the program
//   counter, drives the instruction-memory address and captures the returned
//   word, together with its PC, into the IF/ID pipeline register.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   StallF     hold the PC
//   StallD     hold the IF/ID register
//   FlushD     load a bubble into the IF/ID register
//   PCSrcE     redirect request from execute (taken branch / jump)
//   PCTargetE  redirect target (low two bits are dropped)
//   InstrF     instruction word from the combinational instruction memory
//   PCF        current PC, instruction-memory address
//   InstrD     registered instruction for decode
//   PCD        PC of InstrD
//   PCPlus4D   PCD + 4
//   ValidD     InstrD is a real fetched instruction, not a bubble
//   MisalignF  one-cycle pulse: last redirect target was not word-aligned
module fetch_stage #(
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     StallF,
    input  logic                     StallD,
    input  logic                     FlushD,
    input  logic                     PCSrcE,
    input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
    input  logic [DATA_WIDTH-1:0]    InstrF,
    output logic [ADDRESS_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0]    InstrD,
    output logic [ADDRESS_WIDTH-1:0] PCD,
    output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
    output logic                     ValidD,
    output logic                     MisalignF
);

    // addi x0, x0, 0
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0]    r_instr_d;
    logic [ADDRESS_WIDTH-1:0] r_pc_d;
    logic [ADDRESS_WIDTH-1:0] r_pc_plus4_d;
    logic                     r_valid_d;
    logic                     r_misalign;

    logic [ADDRESS_WIDTH-1:0] w_pc_plus4;
    logic [ADDRESS_WIDTH-1:0] w_target_aligned;
    logic                     w_target_misaligned;

    // Natural overflow gives the required modulo-2^ADDRESS_WIDTH wrap.
    assign w_pc_plus4          = r_pc + ADDRESS_WIDTH'(4);
    assign w_target_aligned    = {PCTargetE[ADDRESS_WIDTH-1:2], 2'b00};
    assign w_target_misaligned = |PCTargetE[1:0];

    // Redirect is checked ahead of StallF so it can never be dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (PCSrcE) begin
            r_pc <= w_target_aligned;
        end else if (!StallF) begin
            r_pc <= w_pc_plus4;
        end
    end

    // Flush is checked ahead of StallD so a stalled bubble still clears.
    always_ff @(posedge clk) begin
        if (rst || FlushD) begin
            r_instr_d    <= NOP;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (!StallD) begin
            r_instr_d    <= InstrF;
            r_pc_d       <= r_pc;
            r_pc_plus4_d <= w_pc_plus4;
            r_valid_d    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= PCSrcE && w_target_misaligned;
        end
    end

    assign PCF       = r_pc;
    assign InstrD    = r_instr_d;
    assign PCD       = r_pc_d;
    assign PCPlus4D  = r_pc_plus4_d;
    assign ValidD    = r_valid_d;
    assign MisalignF = r_misalign;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;

    logic [31:0] instr_f [2];
    logic [31:0] pcf     [2];
    logic [31:0] instr_d [2];
    logic [31:0] pcd     [2];
    logic [31:0] pc4d    [2];
    logic        valid_d [2];
    logic        mis     [2];

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    // Instruction memory: word k holds 0x1000 + k.
    function automatic logic [31:0] mem(input logic [31:0] addr);
        return 32'h1000 + (addr >> 2);
    endfunction

    assign instr_f[0] = mem(pcf[0]);
    assign instr_f[1] = mem(pcf[1]);

    fetch_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .RESET_PC(32'h0)) u_dut0 (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(instr_f[0]),
        .PCF(pcf[0]), .InstrD(instr_d[0]), .PCD(pcd[0]), .PCPlus4D(pc4d[0]),
        .ValidD(valid_d[0]), .MisalignF(mis[0])
    );

    fetch_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) u_dut1 (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(instr_f[1]),
        .PCF(pcf[1]), .InstrD(instr_d[1]), .PCD(pcd[1]), .PCPlus4D(pc4d[1]),
        .ValidD(valid_d[1]), .MisalignF(mis[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: architectural state per instance, advanced once per
    // rising edge from the sampled inputs.
    logic [31:0] reset_pc [2] = '{32'h0, 32'hFFFF_FFF8};
    logic [31:0] m_pc     [2];
    logic [31:0] m_instr  [2];
    logic [31:0] m_pcd    [2];
    logic [31:0] m_pc4    [2];
    logic        m_valid  [2];
    logic        m_mis    [2];
    bit          started = 0;

    always @(posedge clk) begin
        if (rst) started = 1;
        for (int i = 0; i < 2; i++) begin
            logic [31:0] old_pc;
            old_pc = m_pc[i];
            m_mis[i] = !rst && PCSrcE && (PCTargetE % 4 != 0);
            if (rst || FlushD) begin
                m_instr[i] = 32'h13; m_pcd[i] = 0; m_pc4[i] = 0; m_valid[i] = 0;
            end else if (!StallD) begin
                m_instr[i] = mem(old_pc); m_pcd[i] = old_pc;
                m_pc4[i] = old_pc + 4;    m_valid[i] = 1;
            end
            if (rst)          m_pc[i] = reset_pc[i];
            else if (PCSrcE)  m_pc[i] = PCTargetE - (PCTargetE % 4);
            else if (!StallF) m_pc[i] = old_pc + 4;
        end
        #2;
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("pcf%0d", i),    pcf[i],     m_pc[i]);
                check($sformatf("instrd%0d", i), instr_d[i], m_instr[i]);
                check($sformatf("pcd%0d", i),    pcd[i],     m_pcd[i]);
                check($sformatf("pc4d%0d", i),   pc4d[i],    m_pc4[i]);
                check($sformatf("valid%0d", i),  {31'b0, valid_d[i]}, {31'b0, m_valid[i]});
                check($sformatf("mis%0d", i),    {31'b0, mis[i]},     {31'b0, m_mis[i]});
            end
        end
    end

    task automatic idle();
        rst = 0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk); @(negedge clk);
        // reset state
        check("rst_pcf",    pcf[0], 32'h0);
        check("rst_instrd", instr_d[0], 32'h13);
        check("rst_valid",  {31'b0, valid_d[0]}, 32'h0);
        check("rst_mis",    {31'b0, mis[0]}, 32'h0);
        check("rst_pcf_hi", pcf[1], 32'hFFFF_FFF8);
        rst = 0;
        @(negedge clk);
        check("run_pcf4",   pcf[0], 32'h4);
        check("run_instr0", instr_d[0], 32'h1000);
        check("run_pc4d",   pc4d[0], 32'h4);
        check("wrap_fffc",  pcf[1], 32'hFFFF_FFFC);
        @(negedge clk);
        check("run_instr1", instr_d[0], 32'h1001);
        check("wrap_zero",  pcf[1], 32'h0);
        @(negedge clk); @(negedge clk);
        check("pre_stall_pcf", pcf[0], 32'h10);
        // stall both for three cycles
        StallF = 1; StallD = 1;
        repeat (3) @(negedge clk);
        check("stall_pcf",   pcf[0], 32'h10);
        check("stall_instr", instr_d[0], 32'h1003);
        StallF = 0; StallD = 0;
        @(negedge clk);
        check("unstall_pcf",   pcf[0], 32'h14);
        check("unstall_instr", instr_d[0], 32'h1004);
        // redirect with flush
        PCSrcE = 1; PCTargetE = 32'h40; FlushD = 1;
        @(negedge clk);
        check("redir_pcf",   pcf[0], 32'h40);
        check("redir_instr", instr_d[0], 32'h13);
        check("redir_valid", {31'b0, valid_d[0]}, 32'h0);
        idle();
        @(negedge clk);
        check("redir_pcd",    pcd[0], 32'h40);
        check("redir_valid1", {31'b0, valid_d[0]}, 32'h1);
        // priority: redirect over StallF, flush over StallD
        PCSrcE = 1; PCTargetE = 32'h80; StallF = 1; FlushD = 1; StallD = 1;
        @(negedge clk);
        check("prio_pcf",   pcf[0], 32'h80);
        check("prio_instr", instr_d[0], 32'h13);
        check("prio_valid", {31'b0, valid_d[0]}, 32'h0);
        idle();
        // misaligned target
        PCSrcE = 1; PCTargetE = 32'h22;
        @(negedge clk);
        check("mis_pcf",  pcf[0], 32'h20);
        check("mis_set",  {31'b0, mis[0]}, 32'h1);
        idle();
        @(negedge clk);
        check("mis_clr",  {31'b0, mis[0]}, 32'h0);
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 39) == 0);
            StallF    = ($urandom_range(0, 3) == 0);
            StallD    = ($urandom_range(0, 3) == 0);
            FlushD    = ($urandom_range(0, 5) == 0);
            PCSrcE    = ($urandom_range(0, 7) == 0);
            PCTargetE = ($urandom_range(0, 1) == 0) ? $urandom : 32'hFFFF_FFF0 + $urandom_range(0, 15);
            @(negedge clk);
        end
        // reset during a stall
        idle();
        repeat (3) @(negedge clk);
        StallF = 1; StallD = 1; rst = 1;
        @(negedge clk);
        check("midrst_pcf",   pcf[1], 32'hFFFF_FFF8);
        check("midrst_valid", {31'b0, valid_d[1]}, 32'h0);
        idle();
        @(negedge clk);
        check("postrst_instr", instr_d[1], mem(32'hFFFF_FFF8));
        check("postrst_valid", {31'b0, valid_d[1]}, 32'h1);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
